arb_req_tracker: RTL and testbench

Per-client request bookkeeping stage that sits directly upstream of the 4-way round-robin arbiter. Each of four clients posts single-cycle request tokens; the block keeps a saturating pending count per client and drives the arbiter's `request[3:0]` level from those counts. It consumes the arbiter's registered `grant[3:0]` to retire tokens, masking the one-cycle grant latency so no client is ever over-granted.

---
 rtl/arb_req_tracker.sv | 151 +++++++++++++++
 tb/tb_arb_req_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_tracker.sv
// ---------------------------------------------------------------------------
// arb_req_tracker
// Per-client request bookkeeping in front of a 4-way round-robin arbiter.
// Keeps a saturating pending-token count per client and drives the arbiter's
// request level from it. The arbiter's registered grant is masked into the
// request so a client's last token is never granted twice.
//
// Optional feature macro: ARB_REQ_TIMEOUT_EN (per-client starvation check).
//
// Ports:
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   post       : [3:0] one-cycle token post per client
//   post_ready : [3:0] client count below DEPTH (combinational)
//   request    : [3:0] effective pending level to arbiter (combinational)
//   grant      : [3:0] registered one-hot grant from arbiter
//   pend_cnt   : [4*CW-1:0] packed counts, client i at [i*CW +: CW]
//   ovf_err    : sticky, a post was dropped while full
//   spur_err   : sticky, a grant hit a client with zero count
//   starve     : [3:0] sticky per-client starvation flag (0 when disabled)
// ---------------------------------------------------------------------------
module arb_req_tracker #(
   parameter  int unsigned DEPTH   = 7,
   parameter  int unsigned TIMEOUT = 8,
   localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      post,
   output logic [3:0]      post_ready,
   output logic [3:0]      request,
   input  logic [3:0]      grant,
   output logic [4*CW-1:0] pend_cnt,
   output logic            ovf_err,
   output logic            spur_err,
   output logic [3:0]      starve
);

   localparam int unsigned NC = 4;

   if (DEPTH < 1 || DEPTH > 15 || TIMEOUT < 2) begin : g_bad_param
      $error("arb_req_tracker: DEPTH must be 1..15 and TIMEOUT >= 2");
   end

   logic [CW-1:0] cnt_q [NC];
   logic [CW-1:0] cnt_d [NC];
   logic          ovf_q, ovf_d;
   logic          spur_q, spur_d;

   // Status and arbiter-facing request level, straight from the count register
   always_comb begin
      post_ready = '0;
      request    = '0;
      pend_cnt   = '0;
      for (int i = 0; i < NC; i++) begin
         post_ready[i]        = (cnt_q[i] != CW'(DEPTH));
         // Last token under grant this cycle drops request to hide arbiter latency
         request[i]           = (cnt_q[i] > CW'(1)) ||
                                ((cnt_q[i] == CW'(1)) && !grant[i]);
         pend_cnt[i*CW +: CW] = cnt_q[i];
      end
   end

   // Count update and sticky error flags
   always_comb begin
      logic accept;
      logic retire;
      ovf_d  = ovf_q;
      spur_d = spur_q;
      accept = 1'b0;
      retire = 1'b0;
      for (int i = 0; i < NC; i++) begin
         cnt_d[i] = cnt_q[i];
         accept   = post[i] && post_ready[i];
         retire   = grant[i] && (cnt_q[i] != '0);
         if (accept && !grant[i]) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end else if (retire && !accept) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
         end
         if (post[i] && !post_ready[i]) begin
            ovf_d = 1'b1;
         end
         if (grant[i] && (cnt_q[i] == '0)) begin
            spur_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= '0;
         end
         ovf_q  <= 1'b0;
         spur_q <= 1'b0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q  <= ovf_d;
         spur_q <= spur_d;
      end
   end

   assign ovf_err  = ovf_q;
   assign spur_err = spur_q;

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int unsigned AW = $clog2(TIMEOUT + 1);

   logic [AW-1:0] age_q [NC];
   logic [AW-1:0] age_d [NC];
   logic [3:0]    starve_q, starve_d;

   // Age counts consecutive waiting cycles; saturates at TIMEOUT
   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < NC; i++) begin
         age_d[i] = age_q[i];
         if (!request[i] || grant[i]) begin
            age_d[i] = '0;
         end else if (age_q[i] != AW'(TIMEOUT)) begin
            age_d[i] = age_q[i] + AW'(1);
         end
         if (age_d[i] == AW'(TIMEOUT)) begin
            starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NC; i++) begin
            age_q[i] <= '0;
         end
         starve_q <= '0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            age_q[i] <= age_d[i];
         end
         starve_q <= starve_d;
      end
   end

   assign starve = starve_q;
`else
   assign starve = 4'h0;
`endif

endmodule

// File: tb/tb_arb_req_tracker.sv
module tb_arb_req_tracker;

   localparam int unsigned DEPTH   = 7;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CW      = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      post;
   logic [3:0]      post_ready;
   logic [3:0]      request;
   logic [3:0]      grant;
   logic [4*CW-1:0] pend_cnt;
   logic            ovf_err;
   logic            spur_err;
   logic [3:0]      starve;

   // Grant source: small registered lowest-index arbiter, or forced vector
   logic            arb_en;
   logic [3:0]      grant_arb;
   logic [3:0]      grant_frc;
   int              gcnt2;

   int total = 0;
   int bad   = 0;

   assign grant = arb_en ? grant_arb : grant_frc;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst || !arb_en) grant_arb <= 4'h0;
      else                grant_arb <= request & (~request + 4'd1);
      if (grant[2]) gcnt2 <= gcnt2 + 1;
   end

   arb_req_tracker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .post       (post),
      .post_ready (post_ready),
      .request    (request),
      .grant      (grant),
      .pend_cnt   (pend_cnt),
      .ovf_err    (ovf_err),
      .spur_err   (spur_err),
      .starve     (starve)
   );

   function automatic logic [CW-1:0] cnt_of(input int i);
      return pend_cnt[i*CW +: CW];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      post      = 4'h0;
      grant_frc = 4'h0;
      arb_en    = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         total++;
         if ({request, post_ready, pend_cnt, ovf_err, spur_err, starve} !==
             {4'h0, 4'hF, 12'h000, 1'b0, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d req=%b rdy=%b cnt=%h ovf=%b spur=%b starve=%b want req=0000 rdy=1111 cnt=000 ovf=0 spur=0 starve=0000",
                     k, request, post_ready, pend_cnt, ovf_err, spur_err, starve);
         end
         cyc();
      end
   endtask

   task automatic test_single_post();
      do_reset();
      arb_en = 1'b1;
      gcnt2  = 0;
      post   = 4'b0100;
      #1;
      total++;
      if (request !== 4'b0000) begin
         bad++; $display("FAIL post_same_cycle req=%b want 0000", request);
      end
      cyc();
      post = 4'h0;
      #1;
      total++;
      if ({request, grant} !== {4'b0100, 4'b0000}) begin
         bad++; $display("FAIL post_t1 req=%b grant=%b want 0100 0000", request, grant);
      end
      cyc();
      total++;
      if ({grant, request, cnt_of(2)} !== {4'b0100, 4'b0000, 3'd1}) begin
         bad++; $display("FAIL grant_t2 grant=%b req=%b cnt2=%0d want 0100 0000 1", grant, request, cnt_of(2));
      end
      cyc();
      total++;
      if ({grant, request, cnt_of(2)} !== {4'b0000, 4'b0000, 3'd0}) begin
         bad++; $display("FAIL retire_t3 grant=%b req=%b cnt2=%0d want 0000 0000 0", grant, request, cnt_of(2));
      end
      cyc(); cyc(); cyc();
      total++;
      if (gcnt2 !== 1) begin
         bad++; $display("FAIL grant_count got=%0d want 1", gcnt2);
      end
      total++;
      if ({ovf_err, spur_err} !== 2'b00) begin
         bad++; $display("FAIL single_flags ovf=%b spur=%b want 0 0", ovf_err, spur_err);
      end
      arb_en = 1'b0;
   endtask

   task automatic test_saturate();
      do_reset();
      post = 4'b0001;
      for (int k = 1; k <= 8; k++) begin
         #1;
         total++;
         if (post_ready[0] !== (k <= 7)) begin
            bad++; $display("FAIL sat_ready post=%0d got=%b want %b", k, post_ready[0], (k <= 7));
         end
         cyc();
         total++;
         if ({cnt_of(0), ovf_err} !== {((k > 7) ? 3'd7 : 3'(k)), (k == 8)}) begin
            bad++; $display("FAIL sat_cnt post=%0d cnt0=%0d ovf=%b want %0d %b",
                            k, cnt_of(0), ovf_err, (k > 7) ? 7 : k, (k == 8));
         end
      end
      // Post while full with same-cycle grant: post rejected, grant retires
      grant_frc = 4'b0001;
      #1;
      total++;
      if (request[0] !== 1'b1) begin
         bad++; $display("FAIL full_grant_req got=%b want 1", request[0]);
      end
      cyc();
      post = 4'h0; grant_frc = 4'h0;
      #1;
      total++;
      if ({cnt_of(0), ovf_err, post_ready[0]} !== {3'd6, 1'b1, 1'b1}) begin
         bad++; $display("FAIL full_grant cnt0=%0d ovf=%b rdy=%b want 6 1 1", cnt_of(0), ovf_err, post_ready[0]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      post = 4'b0010;
      cyc(); cyc(); cyc();
      post = 4'b0010; grant_frc = 4'b0010;
      cyc();
      total++;
      if ({cnt_of(1), request[1]} !== {3'd3, 1'b1}) begin
         bad++; $display("FAIL post_and_grant cnt1=%0d req1=%b want 3 1", cnt_of(1), request[1]);
      end
      post = 4'h0;
      cyc(); cyc();
      total++;
      if ({cnt_of(1), request[1]} !== {3'd1, 1'b0}) begin
         bad++; $display("FAIL last_token_mask cnt1=%0d req1=%b want 1 0", cnt_of(1), request[1]);
      end
      cyc();
      grant_frc = 4'h0;
      #1;
      total++;
      if ({cnt_of(1), request[1], spur_err} !== {3'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL drain cnt1=%0d req1=%b spur=%b want 0 0 0", cnt_of(1), request[1], spur_err);
      end
   endtask

   task automatic test_spurious_and_reset();
      do_reset();
      grant_frc = 4'b1000;
      cyc();
      grant_frc = 4'h0;
      #1;
      total++;
      if ({spur_err, cnt_of(3), ovf_err} !== {1'b1, 3'd0, 1'b0}) begin
         bad++; $display("FAIL spurious spur=%b cnt3=%0d ovf=%b want 1 0 0", spur_err, cnt_of(3), ovf_err);
      end
      post = 4'hF;
      cyc(); cyc();
      total++;
      if (pend_cnt !== {3'd2, 3'd2, 3'd2, 3'd2}) begin
         bad++; $display("FAIL pre_rst_cnt got=%h want %h", pend_cnt, {3'd2, 3'd2, 3'd2, 3'd2});
      end
      // Reset mid-operation with a grant and posts in flight
      rst = 1'b1; grant_frc = 4'b0001;
      cyc();
      rst = 1'b0; post = 4'h0; grant_frc = 4'h0;
      #1;
      total++;
      if ({pend_cnt, request, post_ready, spur_err, ovf_err} !==
          {12'h000, 4'h0, 4'hF, 1'b0, 1'b0}) begin
         bad++; $display("FAIL mid_reset cnt=%h req=%b rdy=%b spur=%b ovf=%b want 000 0000 1111 0 0",
                         pend_cnt, request, post_ready, spur_err, ovf_err);
      end
   endtask

   task automatic test_starve();
      logic exp;
      do_reset();
      post = 4'b0001;
      cyc();
      post = 4'h0;
      for (int k = 1; k <= 9; k++) begin
         cyc();
`ifdef ARB_REQ_TIMEOUT_EN
         exp = (k >= 8);
`else
         exp = 1'b0;
`endif
         total++;
         if (starve !== {3'b000, exp}) begin
            bad++; $display("FAIL starve wait=%0d got=%b want %b", k, starve, {3'b000, exp});
         end
      end
   endtask

   initial begin
      rst = 1'b1; post = 4'h0; grant_frc = 4'h0; arb_en = 1'b0; gcnt2 = 0;
      test_reset();
      test_single_post();
      test_saturate();
      test_back_to_back();
      test_spurious_and_reset();
      test_starve();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
